// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the pipelined RISC-V core front end.
//   XLEN         : architectural register / PC width
//   RESET_PC     : default first fetch address after reset
//   NOP_INSTR    : canonical nop (addi x0, x0, 0) used by downstream stages
//                  when they need to insert a bubble
//   fd_payload_t : {pc, instr} pair carried from fetch to decode
package riscv_pkg;

    localparam int unsigned     XLEN      = 32;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fd_payload_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Small instruction buffer between instruction memory and the F/D register.
// Entry 0 is always the head, so the head payload comes straight out of a
// flop with no read-side mux.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   push        : write push_data behind the current contents
//   push_data   : {pc, instr} to store
//   pop         : drop the head entry (only meaningful while head_valid)
//   flush       : discard all entries; overrides push and pop
//   count       : number of valid entries (0..DEPTH)
//   head_valid  : count != 0
//   head        : payload of the oldest entry
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fd_payload_t   push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          head_valid,
    output fd_payload_t   head
);

    fd_payload_t   entries [DEPTH];
    logic [CW-1:0] wr_idx;

    // A simultaneous pop shifts everything down one slot, so the new entry
    // lands one position lower than the current count.
    assign wr_idx = count - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && wr_idx == CW'(i)) begin
                    entries[i] <= push_data;
                end else if (pop) begin
                    // The top slot picks up a wrapped copy; it is beyond
                    // count afterwards, so its content is irrelevant.
                    entries[i] <= entries[(i + 1) % DEPTH];
                end
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_valid = (count != '0);
    assign head       = entries[0];

    // Upstream credit accounting must never let a push reach a full buffer.
    fifo_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        (push && !flush) |-> (wr_idx < CW'(DEPTH))
    );

endmodule

// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage
// Instruction fetch stage: owns the PC, issues in-order word fetches and
// buffers returned instructions until decode accepts them.
// Ports:
//   clk_i, reset_ni         : clock (rising edge), asynchronous active-low reset
//   imem_req_o, imem_addr_o : one-cycle fetch request and word address
//   imem_rvalid_i/rdata_i   : in-order response, latency >= 1 cycle
//   redirect_i/redirect_pc_i: flush everything and restart at the target
//   fd_valid_o/fd_ready_i   : handshake with the F/D register (FD_pipeready)
//   fd_pc_o/fd_instr_o      : head {pc, instr}
module riscv_fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = riscv_pkg::RESET_PC,
    parameter int unsigned      DEPTH    = 2
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            fd_valid_o,
    input  logic            fd_ready_i,
    output logic [XLEN-1:0] fd_pc_o,
    output logic [XLEN-1:0] fd_instr_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic            run_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] resp_pc_q;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   discard_q;

    logic [CW-1:0]   fifo_count;
    logic            head_valid;
    fd_payload_t     head;
    fd_payload_t     push_data;

    logic            pop_req;
    logic            fifo_pop;
    logic            fifo_push;
    logic            issue;
    logic [SW-1:0]   credit_used;
    logic [XLEN-1:0] redirect_target;

    // pop_req is the raw handshake; the credit check counts it even in a
    // redirect cycle, which is harmless because a redirect blocks issue anyway.
    assign pop_req   = head_valid & fd_ready_i;
    assign fifo_pop  = pop_req & ~redirect_i;
    assign fifo_push = imem_rvalid_i & (discard_q == '0) & ~redirect_i;

    // Every in-flight request owns a FIFO slot, so capping in-flight plus
    // buffered at DEPTH makes overflow impossible for any memory latency.
    assign credit_used = SW'(outstanding_q) + SW'(fifo_count) - SW'(pop_req);
    assign issue       = run_q & ~redirect_i & (credit_used < SW'(DEPTH));

    assign imem_req_o      = issue;
    assign imem_addr_o     = pc_q;
    assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};

    assign push_data.pc    = resp_pc_q;
    assign push_data.instr = imem_rdata_i;

    // run_q holds off the first request until one full edge after reset
    // release, so memory coming out of the same reset sees a clean start.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Redirect replaces discard_q outright: whatever is still in flight after
    // this cycle (a response arriving now is already gone) belongs to the old
    // path, including leftovers from an earlier redirect.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_q + CW'(issue) - CW'(imem_rvalid_i);
            if (redirect_i) begin
                pc_q      <= redirect_target;
                resp_pc_q <= redirect_target;
                discard_q <= outstanding_q - CW'(imem_rvalid_i);
            end else begin
                if (issue) begin
                    pc_q <= pc_q + XLEN'(4);
                end
                if (imem_rvalid_i) begin
                    if (discard_q != '0) begin
                        discard_q <= discard_q - CW'(1);
                    end else begin
                        resp_pc_q <= resp_pc_q + XLEN'(4);
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk_i),
        .rst_n      (reset_ni),
        .push       (fifo_push),
        .push_data  (push_data),
        .pop        (fifo_pop),
        .flush      (redirect_i),
        .count      (fifo_count),
        .head_valid (head_valid),
        .head       (head)
    );

    assign fd_valid_o = head_valid;
    assign fd_pc_o    = head.pc;
    assign fd_instr_o = head.instr;

endmodule
